// File: rtl/multi_cycle_controller.sv
// Multi-cycle control FSM: fetch/decode/execute/memory/writeback sequencing with a mem_ready stall handshake.
// Optional feature macro CTRL_ILLEGAL_TRAP_EN: unknown opcodes park the FSM in TRAP and assert illegal_op.
module multi_cycle_controller #(
    parameter int MEM_HS   = 1,
    parameter int ALU_OP_W = 3,
    parameter int STATE_W  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          opcode,
    input  logic                mem_ready,
    output logic                pc_w,
    output logic                pc_w_cond,
    output logic                branch_ne,
    output logic                i_or_d,
    output logic                mem_r,
    output logic                mem_w,
    output logic                ir_w,
    output logic                mem_to_reg,
    output logic                reg_dst,
    output logic                reg_w,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          pc_src,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                instr_done,
`ifdef CTRL_ILLEGAL_TRAP_EN
    output logic                illegal_op,
`endif
    output logic [STATE_W-1:0]  state
);

    localparam logic [STATE_W-1:0] S_FETCH    = STATE_W'(4'd0);
    localparam logic [STATE_W-1:0] S_DECODE   = STATE_W'(4'd1);
    localparam logic [STATE_W-1:0] S_MEM_ADDR = STATE_W'(4'd2);
    localparam logic [STATE_W-1:0] S_MEM_RD   = STATE_W'(4'd3);
    localparam logic [STATE_W-1:0] S_MEM_WB   = STATE_W'(4'd4);
    localparam logic [STATE_W-1:0] S_MEM_WR   = STATE_W'(4'd5);
    localparam logic [STATE_W-1:0] S_EXEC     = STATE_W'(4'd6);
    localparam logic [STATE_W-1:0] S_ALU_WB   = STATE_W'(4'd7);
    localparam logic [STATE_W-1:0] S_BRANCH   = STATE_W'(4'd8);
    localparam logic [STATE_W-1:0] S_JUMP     = STATE_W'(4'd9);
    localparam logic [STATE_W-1:0] S_IMM_EXEC = STATE_W'(4'd10);
    localparam logic [STATE_W-1:0] S_IMM_WB   = STATE_W'(4'd11);
`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam logic [STATE_W-1:0] S_TRAP     = STATE_W'(4'd12);
`endif

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    localparam logic [ALU_OP_W-1:0] ALU_ADD   = ALU_OP_W'(3'b000);
    localparam logic [ALU_OP_W-1:0] ALU_SUB   = ALU_OP_W'(3'b001);
    localparam logic [ALU_OP_W-1:0] ALU_FUNCT = ALU_OP_W'(3'b010);
    localparam logic [ALU_OP_W-1:0] ALU_AND   = ALU_OP_W'(3'b011);
    localparam logic [ALU_OP_W-1:0] ALU_OR    = ALU_OP_W'(3'b100);
    localparam logic [ALU_OP_W-1:0] ALU_SLT   = ALU_OP_W'(3'b101);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic               mem_rdy_s;

    // Without the handshake every memory access is treated as completing at once.
    assign mem_rdy_s = (MEM_HS == 0) ? 1'b1 : mem_ready;
    assign state     = state_q;

    // State register with synchronous reset to FETCH.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = mem_rdy_s ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:                         state_d = S_EXEC;
                    OP_LW, OP_SW:                     state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:                   state_d = S_BRANCH;
                    OP_J:                             state_d = S_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_IMM_EXEC;
`ifdef CTRL_ILLEGAL_TRAP_EN
                    default:                          state_d = S_TRAP;
`else
                    default:                          state_d = S_FETCH;
`endif
                endcase
            end
            S_MEM_ADDR: state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   state_d = mem_rdy_s ? S_MEM_WB : S_MEM_RD;
            S_MEM_WB:   state_d = S_FETCH;
            S_MEM_WR:   state_d = mem_rdy_s ? S_FETCH : S_MEM_WR;
            S_EXEC:     state_d = S_ALU_WB;
            S_ALU_WB:   state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            S_IMM_EXEC: state_d = S_IMM_WB;
            S_IMM_WB:   state_d = S_FETCH;
`ifdef CTRL_ILLEGAL_TRAP_EN
            S_TRAP:     state_d = S_TRAP;
`endif
            default:    state_d = S_FETCH;
        endcase
    end

    // Output decode; reset forces every control output low, write strobes included.
    always_comb begin
        pc_w       = 1'b0;
        pc_w_cond  = 1'b0;
        branch_ne  = 1'b0;
        i_or_d     = 1'b0;
        mem_r      = 1'b0;
        mem_w      = 1'b0;
        ir_w       = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        reg_w      = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        alu_op     = ALU_ADD;
        instr_done = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
        illegal_op = 1'b0;
`endif
        if (rst) begin
            mem_w = 1'b0;
            reg_w = 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    mem_r     = 1'b1;
                    alu_src_b = 2'b01;
                    ir_w      = mem_rdy_s;
                    pc_w      = mem_rdy_s;
                end
                S_DECODE:   alu_src_b = 2'b11;
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEM_RD: begin
                    mem_r  = 1'b1;
                    i_or_d = 1'b1;
                end
                S_MEM_WB: begin
                    reg_w      = 1'b1;
                    mem_to_reg = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEM_WR: begin
                    mem_w      = 1'b1;
                    i_or_d     = 1'b1;
                    instr_done = mem_rdy_s;
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_FUNCT;
                end
                S_ALU_WB: begin
                    reg_w      = 1'b1;
                    reg_dst    = 1'b1;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a  = 1'b1;
                    alu_op     = ALU_SUB;
                    pc_w_cond  = 1'b1;
                    pc_src     = 2'b01;
                    branch_ne  = opcode[0];
                    instr_done = 1'b1;
                end
                S_JUMP: begin
                    pc_w       = 1'b1;
                    pc_src     = 2'b10;
                    instr_done = 1'b1;
                end
                S_IMM_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    case (opcode)
                        OP_ANDI: alu_op = ALU_AND;
                        OP_ORI:  alu_op = ALU_OR;
                        OP_SLTI: alu_op = ALU_SLT;
                        default: alu_op = ALU_ADD;
                    endcase
                end
                S_IMM_WB: begin
                    reg_w      = 1'b1;
                    instr_done = 1'b1;
                end
`ifdef CTRL_ILLEGAL_TRAP_EN
                S_TRAP:     illegal_op = 1'b1;
`endif
                default:    mem_r = 1'b0;
            endcase
        end
    end

endmodule

// File: doc/multi_cycle_controller.md
Name: multi_cycle_controller

Overview:
- Parametrised multi-cycle successor to the single-cycle main decoder.
- Decodes the 6-bit opcode through a Moore/Mealy FSM and sequences shared-memory fetch, decode, execute, memory and writeback.
- Stalls on a memory ready handshake.
- Sits between the instruction register and the multi-cycle datapath: one ALU, one memory port, IR and temp registers.

Parameters:
- MEM_HS, 1, 1 = FETCH/MEM_RD/MEM_WR wait for mem_ready; 0 = mem_ready ignored, memory assumed single-cycle.
- ALU_OP_W, 3, alu_op width; must be >= 3, upper bits driven 0.
- STATE_W, 4, state register width; must be >= 4.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- opcode  in  6  IR[31:26], valid from DECODE onward
- mem_ready  in  1  memory access completes this cycle
- pc_w  out  1  unconditional PC write
- pc_w_cond  out  1  PC write if branch condition true
- branch_ne  out  1  0 = beq condition (zero), 1 = bne (!zero)
- i_or_d  out  1  memory address: 0 = PC, 1 = ALUOut
- mem_r  out  1  memory read request
- mem_w  out  1  memory write request
- ir_w  out  1  IR load
- mem_to_reg  out  1  writeback source: 1 = MDR
- reg_dst  out  1  1 = rd, 0 = rt
- reg_w  out  1  register file write
- alu_src_a  out  1  0 = PC, 1 = A
- alu_src_b  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 imm<<2
- pc_src  out  2  00 ALU, 01 ALUOut, 10 jump target
- alu_op  out  ALU_OP_W  000 add, 001 sub, 010 funct, 011 and, 100 or, 101 slt
- instr_done  out  1  one-cycle pulse on the final cycle of each instruction
- state  out  STATE_W  current state, for debug

Behaviour:
- States: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC=6, ALU_WB=7, BRANCH=8, JUMP=9, IMM_EXEC=10, IMM_WB=11, TRAP=12.
- Reset: while rst=1, every output is 0 except state. Next state is FETCH. The first post-reset cycle is FETCH.
- FETCH:
  - Drives mem_r=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=add, pc_src=00.
  - ir_w and pc_w are asserted only while mem_ready=1 (Mealy).
  - Advances to DECODE on mem_ready; otherwise holds with no PC/IR writes.
- DECODE:
  - Drives alu_src_a=0, alu_src_b=11, alu_op=add (branch target).
  - Next state by opcode:
    - 000000 -> EXEC
    - 100011, 101011 -> MEM_ADDR
    - 000100, 000101 -> BRANCH
    - 000010 -> JUMP
    - 001000, 001100, 001101, 001010 -> IMM_EXEC
    - any other -> TRAP (if enabled) else FETCH
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=add. lw -> MEM_RD, sw -> MEM_WR.
- MEM_RD: mem_r=1, i_or_d=1. Holds until mem_ready, then -> MEM_WB.
- MEM_WB: reg_w=1, mem_to_reg=1, reg_dst=0, instr_done=1 -> FETCH.
- MEM_WR: mem_w=1, i_or_d=1. Holds until mem_ready; on that cycle instr_done=1 and -> FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=funct -> ALU_WB.
- ALU_WB: reg_w=1, reg_dst=1, mem_to_reg=0, instr_done=1 -> FETCH.
- BRANCH:
  - Drives alu_src_a=1, alu_src_b=00, alu_op=sub, pc_w_cond=1, pc_src=01, instr_done=1 -> FETCH.
  - branch_ne = opcode[0].
- JUMP: pc_w=1, pc_src=10, instr_done=1 -> FETCH.
- IMM_EXEC:
  - Drives alu_src_a=1, alu_src_b=10 -> IMM_WB.
  - alu_op: addi = add, andi = and, ori = or, slti = slt.
- IMM_WB: reg_w=1, reg_dst=0, mem_to_reg=0, instr_done=1 -> FETCH.
- mem_r and mem_w are never both 1. Request signals stay asserted and stable for the whole wait.
- MEM_HS=0: every mem_ready term is treated as 1.
- rst asserted mid-instruction, including during a memory wait: next cycle is FETCH, and no write strobe is asserted on the reset cycle.
- Unlisted state encodings -> FETCH.
- Cycle counts at MEM_HS=1 with zero wait:
  - lw 5
  - sw 4
  - R-type, immediate 4
  - branch, jump 3

Optional Feature:
- CTRL_ILLEGAL_TRAP_EN defined:
  - An unknown opcode in DECODE -> TRAP.
  - TRAP drives all strobes 0 and holds until rst.
  - Extra output illegal_op (1 bit) is 1 in TRAP, 0 otherwise, including during reset.
- Not defined:
  - No TRAP state and no illegal_op port.
  - An unknown opcode returns to FETCH with no register or memory write and no instr_done.

Test Plan:
- Reset, then R-type (opcode 000000), mem_ready tied 1 -> states 0,1,6,7,0; reg_w=1 and reg_dst=1 only in cycle 4; instr_done pulses once.
- lw (100011) with mem_ready low for 2 cycles in MEM_RD -> states 0,1,2,3,3,3,4; mem_r and i_or_d stay 1 through the stall; reg_w only in state 4.
- FETCH with mem_ready=0 for 3 cycles -> pc_w=0 and ir_w=0 during the stall; both 1 only on the ready cycle.
- bne (000101), then beq (000100) -> BRANCH with pc_w_cond=1, pc_src=01, alu_op=001; branch_ne 1 then 0.
- ori (001101) -> IMM_EXEC alu_op=100, alu_src_b=10, then IMM_WB reg_w=1, reg_dst=0; j (000010) -> JUMP pc_w=1, pc_src=10.
- rst pulsed in MEM_WR with mem_ready=0, then opcode 111111 -> FETCH next cycle with mem_w=0; with CTRL_ILLEGAL_TRAP_EN, state=12 and illegal_op=1 held until rst.
